// File: rtl/lc3_decode_if.sv
// -----------------------------------------------------------------------------
// lc3_decode_if
// Bundle of the LC3 decode stage's instruction handshake, register-file write
// port and issued-operation outputs.
//   instr_valid / instr / instr_ready : instruction offer and acceptance.
//   stall                             : downstream hold request.
//   wb_en / wb_dr / wb_data           : register-file write port.
//   alu_enable / alu_control /
//   aluin1 / aluin2 / dr_out          : registered command to the ALU stage.
//   illegal                           : one-cycle pulse for a non-ALU opcode.
// Modports: master drives instructions and write-backs; slave is the decoder.
// -----------------------------------------------------------------------------
interface lc3_decode_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        stall;
    logic        wb_en;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        alu_enable;
    logic [1:0]  alu_control;
    logic [15:0] aluin1;
    logic [15:0] aluin2;
    logic [2:0]  dr_out;
    logic        illegal;

    modport master (
        output instr_valid, instr, stall, wb_en, wb_dr, wb_data,
        input  instr_ready, alu_enable, alu_control, aluin1, aluin2, dr_out, illegal
    );

    modport slave (
        input  instr_valid, instr, stall, wb_en, wb_dr, wb_data,
        output instr_ready, alu_enable, alu_control, aluin1, aluin2, dr_out, illegal
    );
endinterface

// File: rtl/lc3_decode.sv
// -----------------------------------------------------------------------------
// lc3_decode
// Decode/issue stage for the LC3 ADD, AND and NOT instructions. Holds the
// 8x16 register file and a per-register busy scoreboard, reads operands,
// and issues a registered ALU command one cycle after acceptance.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : lc3_decode_if.slave (handshake, write-back port, ALU outputs)
// Build option:
//   LC3_DECODE_BYPASS_EN : when defined, a source being written back in the
//   same cycle is not hazarded and takes wb_data directly. When undefined,
//   such a source waits until the cycle after the write-back.
// -----------------------------------------------------------------------------
module lc3_decode (
    input  logic         clk,
    input  logic         rst,
    lc3_decode_if.slave  bus
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_AND = 2'd1,
        ALU_NOT = 2'd2
    } alu_op_e;

    logic [15:0] rf [8];
    logic [7:0]  busy;

    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        legal;
    alu_op_e     alu_op;
    logic        uses_sr2;
    logic        sr1_hit;
    logic        sr2_hit;
    logic        sr1_haz;
    logic        sr2_haz;
    logic [15:0] sr1_val;
    logic [15:0] sr2_val;
    logic [15:0] imm;
    logic [15:0] op2;
    logic        ready;
    logic        accept;
    logic        issue;

    // Decode, hazard detection and operand selection.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        opcode   = bus.instr[15:12];
        dr       = bus.instr[11:9];
        sr1      = bus.instr[8:6];
        sr2      = bus.instr[2:0];
        legal    = 1'b0;
        alu_op   = ALU_ADD;

        case (opcode)
            OP_ADD: begin legal = 1'b1; alu_op = ALU_ADD; end
            OP_AND: begin legal = 1'b1; alu_op = ALU_AND; end
            OP_NOT: begin legal = 1'b1; alu_op = ALU_NOT; end
            default: ;
        endcase

        // SR2 is a real source only for register-form ADD/AND.
        uses_sr2 = legal && (alu_op != ALU_NOT) && !bus.instr[5];

        sr1_hit  = bus.wb_en && (bus.wb_dr == sr1);
        sr2_hit  = bus.wb_en && (bus.wb_dr == sr2);

`ifdef LC3_DECODE_BYPASS_EN
        // The write-back in flight this cycle satisfies the dependency.
        sr1_haz  = busy[sr1] && !sr1_hit;
        sr2_haz  = busy[sr2] && !sr2_hit;
        sr1_val  = sr1_hit ? bus.wb_data : rf[sr1];
        sr2_val  = sr2_hit ? bus.wb_data : rf[sr2];
`else
        // The register file only reflects a write-back after its edge, so a
        // source being written this cycle must wait one more cycle.
        sr1_haz  = busy[sr1] || sr1_hit;
        sr2_haz  = busy[sr2] || sr2_hit;
        sr1_val  = rf[sr1];
        sr2_val  = rf[sr2];
`endif

        imm = {{11{bus.instr[4]}}, bus.instr[4:0]};

        if (alu_op == ALU_NOT) begin
            op2 = 16'h0000;
        end else if (bus.instr[5]) begin
            op2 = imm;
        end else begin
            op2 = sr2_val;
        end

        // Non-ALU opcodes read no sources, so they never wait on the scoreboard.
        ready  = !bus.stall && !(legal && (sr1_haz || (uses_sr2 && sr2_haz)));
        accept = bus.instr_valid && ready;
        issue  = accept && legal;
    end

    assign bus.instr_ready = ready;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is reset explicitly because software
            // relies on every register reading zero after reset.
            for (int i = 0; i < 8; i++) begin
                rf[i] <= 16'h0000;
            end
            busy            <= 8'h00;
            bus.alu_enable  <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.alu_control <= 2'd0;
            bus.aluin1      <= 16'h0000;
            bus.aluin2      <= 16'h0000;
            bus.dr_out      <= 3'd0;
        end else begin
            if (bus.wb_en) begin
                rf[bus.wb_dr]   <= bus.wb_data;
                busy[bus.wb_dr] <= 1'b0;
            end
            // NOTE: this set comes after the write-back clear, so when both
            // target the same register on one edge the set takes effect.
            if (issue) begin
                busy[dr] <= 1'b1;
            end

            bus.alu_enable <= issue;
            bus.illegal    <= accept && !legal;

            // Operand registers hold unless a new ALU operation issues.
            if (issue) begin
                bus.alu_control <= alu_op;
                bus.aluin1      <= sr1_val;
                bus.aluin2      <= op2;
                bus.dr_out      <= dr;
            end
        end
    end

endmodule

// File: tb/tb_lc3_decode.sv
// -----------------------------------------------------------------------------
// tb_lc3_decode
// Self-checking bench for lc3_decode. Directed vectors drive the interface;
// a behavioural model of the register file, scoreboard and issued operation
// is compared against the DUT on every falling edge, and literal checks pin
// the key scenarios (ADD/AND/NOT issue, RAW hazard, illegal, stall, reset).
// Honours LC3_DECODE_BYPASS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_lc3_decode;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lc3_decode_if bus ();

    lc3_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef LC3_DECODE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge.
    task automatic drive(input logic v, input logic [15:0] i, input logic s,
                         input logic we, input logic [2:0] wd, input logic [15:0] wdat);
        @(posedge clk);
        #1;
        bus.instr_valid = v;
        bus.instr       = i;
        bus.stall       = s;
        bus.wb_en       = we;
        bus.wb_dr       = wd;
        bus.wb_data     = wdat;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_rf [8];
    bit          m_busy [8];
    logic        m_en   = 1'b0;
    logic        m_ill  = 1'b0;
    logic [1:0]  m_ctrl = 2'd0;
    logic [15:0] m_a1   = 16'h0000;
    logic [15:0] m_a2   = 16'h0000;
    logic [2:0]  m_dr   = 3'd0;

    function automatic logic [15:0] sext5(input logic [4:0] f);
        int v;
        v = int'(f);
        if (f[4]) v = v - 32;
        return 16'(v);
    endfunction

    function automatic bit blocked(input bit is_busy, input bit wb_hit);
        if (BYPASS) return is_busy && !wb_hit;
        return is_busy || wb_hit;
    endfunction

    function automatic logic [15:0] src_value(input logic [15:0] reg_val, input bit wb_hit,
                                              input logic [15:0] wdat);
        if (BYPASS && wb_hit) return wdat;
        return reg_val;
    endfunction

    initial begin : model
        logic [3:0]  op;
        logic [2:0]  s1, s2, d;
        bit          is_legal, need2, h1, h2, hit1, hit2, exp_ready, take;
        logic [15:0] v1, v2;

        for (int i = 0; i < 8; i++) begin
            m_rf[i]   = 16'h0000;
            m_busy[i] = 1'b0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("alu_enable",  16'(bus.alu_enable),  16'(m_en));
            check("illegal",     16'(bus.illegal),     16'(m_ill));
            check("alu_control", 16'(bus.alu_control), 16'(m_ctrl));
            check("aluin1",      bus.aluin1,           m_a1);
            check("aluin2",      bus.aluin2,           m_a2);
            check("dr_out",      16'(bus.dr_out),      16'(m_dr));

            op       = bus.instr[15:12];
            d        = bus.instr[11:9];
            s1       = bus.instr[8:6];
            s2       = bus.instr[2:0];
            is_legal = (op == 4'h1) || (op == 4'h5) || (op == 4'h9);
            need2    = (op != 4'h9) && !bus.instr[5];
            hit1     = bus.wb_en && (bus.wb_dr == s1);
            hit2     = bus.wb_en && (bus.wb_dr == s2);
            h1       = blocked(m_busy[s1], hit1);
            h2       = blocked(m_busy[s2], hit2);
            exp_ready = !bus.stall && !(is_legal && (h1 || (need2 && h2)));
            check("instr_ready", 16'(bus.instr_ready), 16'(exp_ready));

            v1   = src_value(m_rf[s1], hit1, bus.wb_data);
            v2   = src_value(m_rf[s2], hit2, bus.wb_data);
            take = bus.instr_valid && exp_ready;

            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    m_rf[i]   = 16'h0000;
                    m_busy[i] = 1'b0;
                end
                m_en = 1'b0; m_ill = 1'b0; m_ctrl = 2'd0;
                m_a1 = 16'h0000; m_a2 = 16'h0000; m_dr = 3'd0;
            end else begin
                m_en  = take && is_legal;
                m_ill = take && !is_legal;
                if (m_en) begin
                    m_ctrl = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
                    m_a1   = v1;
                    if (op == 4'h9)          m_a2 = 16'h0000;
                    else if (bus.instr[5])   m_a2 = sext5(bus.instr[4:0]);
                    else                     m_a2 = v2;
                    m_dr   = d;
                end
                if (bus.wb_en) begin
                    m_rf[bus.wb_dr]   = bus.wb_data;
                    m_busy[bus.wb_dr] = 1'b0;
                end
                if (m_en) m_busy[d] = 1'b1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : stimulus
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.stall       = 1'b0;
        bus.wb_en       = 1'b0;
        bus.wb_dr       = 3'd0;
        bus.wb_data     = 16'h0000;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_alu_enable", 16'(bus.alu_enable), 16'd0);
        check("rst_illegal",    16'(bus.illegal),    16'd0);
        check("rst_aluin1",     bus.aluin1,          16'h0000);
        check("rst_dr_out",     16'(bus.dr_out),     16'd0);

        // R1 = 5, R2 = 3, then ADD R3,R1,R2
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 16'h0005);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h0003);
        drive(1'b1, 16'h1642, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("add_ready", 16'(bus.instr_ready), 16'd1);

        // AND R4,R1,#-1 offered while the ADD result is visible
        drive(1'b1, 16'h587F, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("add_alu_enable",  16'(bus.alu_enable),  16'd1);
        check("add_alu_control", 16'(bus.alu_control), 16'd0);
        check("add_aluin1",      bus.aluin1,           16'h0005);
        check("add_aluin2",      bus.aluin2,           16'h0003);
        check("add_dr_out",      16'(bus.dr_out),      16'd3);

        // NOT R5,R1
        drive(1'b1, 16'h9A7F, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("and_alu_control", 16'(bus.alu_control), 16'd1);
        check("and_aluin1",      bus.aluin1,           16'h0005);
        check("and_aluin2",      bus.aluin2,           16'hFFFF);
        check("and_dr_out",      16'(bus.dr_out),      16'd4);

        idle();
        @(negedge clk);
        check("not_alu_enable",  16'(bus.alu_enable),  16'd1);
        check("not_alu_control", 16'(bus.alu_control), 16'd2);
        check("not_aluin2",      bus.aluin2,           16'h0000);
        check("not_dr_out",      16'(bus.dr_out),      16'd5);

        idle();
        @(negedge clk);
        check("idle_alu_enable", 16'(bus.alu_enable), 16'd0);

        // RAW hazard: ADD R6,R3,R3 while R3 is still busy
        drive(1'b1, 16'h1CC3, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("raw_ready_0", 16'(bus.instr_ready), 16'd0);
        drive(1'b1, 16'h1CC3, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("raw_ready_1", 16'(bus.instr_ready), 16'd0);
        drive(1'b1, 16'h1CC3, 1'b0, 1'b1, 3'd3, 16'h0008);
        @(negedge clk);
        check("raw_ready_wb", 16'(bus.instr_ready), 16'(BYPASS));
`ifndef LC3_DECODE_BYPASS_EN
        drive(1'b1, 16'h1CC3, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("raw_ready_after_wb", 16'(bus.instr_ready), 16'd1);
`endif
        idle();
        @(negedge clk);
        check("raw_alu_enable", 16'(bus.alu_enable), 16'd1);
        check("raw_aluin1",     bus.aluin1,          16'h0008);
        check("raw_aluin2",     bus.aluin2,          16'h0008);
        check("raw_dr_out",     16'(bus.dr_out),     16'd6);

        // Illegal opcode (BR 0x0000), then ADD R0,R0,#1 proves R0 stayed free
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("br_ready", 16'(bus.instr_ready), 16'd1);
        drive(1'b1, 16'h1021, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("br_illegal",    16'(bus.illegal),    16'd1);
        check("br_alu_enable", 16'(bus.alu_enable), 16'd0);
        check("br_held_aluin1", bus.aluin1,         16'h0008);
        check("r0_ready",      16'(bus.instr_ready), 16'd1);
        idle();
        @(negedge clk);
        check("br_illegal_end", 16'(bus.illegal),   16'd0);
        check("r0_aluin1",     bus.aluin1,          16'h0000);
        check("r0_aluin2",     bus.aluin2,          16'h0001);
        check("r0_dr_out",     16'(bus.dr_out),     16'd0);

        // Stall for three cycles with ADD R3,R1,R2 offered
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'h1642, 1'b1, 1'b0, 3'd0, 16'h0000);
            @(negedge clk);
            check("stall_ready",      16'(bus.instr_ready), 16'd0);
            check("stall_alu_enable", 16'(bus.alu_enable),  16'd0);
            check("stall_aluin2",     bus.aluin2,           16'h0001);
        end
        drive(1'b1, 16'h1642, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("unstall_ready", 16'(bus.instr_ready), 16'd1);
        idle();
        @(negedge clk);
        check("unstall_alu_enable", 16'(bus.alu_enable), 16'd1);
        check("unstall_aluin1",     bus.aluin1,          16'h0005);
        check("unstall_aluin2",     bus.aluin2,          16'h0003);

        // Reset on the edge that would accept ADD R7,R1,R2
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h1E42;
        @(negedge clk);
        check("rstacc_ready", 16'(bus.instr_ready), 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        @(negedge clk);
        check("rstacc_alu_enable", 16'(bus.alu_enable), 16'd0);
        check("rstacc_aluin1",     bus.aluin1,          16'h0000);
        check("rstacc_dr_out",     16'(bus.dr_out),     16'd0);

        // R3 was busy before reset; it must be free and R1/R2 must read zero
        drive(1'b1, 16'h1642, 1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("post_rst_ready", 16'(bus.instr_ready), 16'd1);
        idle();
        @(negedge clk);
        check("post_rst_alu_enable", 16'(bus.alu_enable), 16'd1);
        check("post_rst_r1",         bus.aluin1,          16'h0000);
        check("post_rst_r2",         bus.aluin2,          16'h0000);

        repeat (3) idle();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/lc3_decode.md
LC3_DECODE -- requirements
Module: lc3_decode

Interface
REQ-001 SHALL have ports, clock and reset first: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-002 SHALL have instr_valid input 1: instr holds an instruction offered this cycle.
REQ-003 SHALL have instr input 16: LC3 instruction word.
REQ-004 SHALL have instr_ready output 1: instruction accepted at this rising edge when instr_valid is also 1.
REQ-005 SHALL have stall input 1: downstream hold request.
REQ-006 SHALL have wb_en input 1, wb_dr input 3, wb_data input 16: register-file write port.
REQ-007 SHALL have alu_enable output 1, alu_control output 2, aluin1 output 16, aluin2 output 16: registered operands and command to the ALU stage.
REQ-008 SHALL have dr_out output 3: destination register of the issued operation.
REQ-009 SHALL have illegal output 1: one-cycle pulse when an accepted opcode is not ADD, AND or NOT.

Function
REQ-010 SHALL hold an internal 8x16 register file R0-R7, written on the rising edge when wb_en=1 (R[wb_dr] <= wb_data).
REQ-011 SHALL decode the opcode in instr[15:12]: 0001 ADD -> alu_control 0; 0101 AND -> 1; 1001 NOT -> 2.
REQ-012 SHALL take DR from instr[11:9] and SR1 from instr[8:6]; aluin1 = R[SR1].
REQ-013 SHALL set aluin2 for ADD/AND to sign-extended instr[4:0] when instr[5]=1, else R[instr[2:0]]; for NOT aluin2 = 16'h0000.
REQ-014 SHALL keep a busy bit per register; a source is hazarded when its busy bit is 1 (SR2 only when instr[5]=0 and the opcode is ADD/AND).
REQ-015 SHALL drive instr_ready = !stall && no source hazard (combinational).
REQ-016 SHALL, on accept of ADD/AND/NOT, set busy[DR] and register alu_enable=1, alu_control, aluin1, aluin2 and dr_out, all valid in the cycle after the accepting edge (latency 1).
REQ-017 SHALL clear busy[wb_dr] on any edge with wb_en=1; when the same edge also sets busy for the same register, the set SHALL win.
REQ-018 SHALL, on accept of any other opcode, pulse illegal=1 for one cycle, keep alu_enable=0 and leave busy bits unchanged.
REQ-019 SHALL drive alu_enable=0 in any cycle following an edge with no accept.
REQ-020 SHALL, while stall=1, accept nothing, hold aluin1, aluin2, alu_control and dr_out, and drive alu_enable=0.
REQ-021 SHALL ignore instr when instr_valid=0, with no register-file or busy side effects.

Reset
REQ-022 SHALL, on a rising edge with rst=1, clear R0-R7 to 16'h0000, all busy bits to 0, alu_enable=0, illegal=0, alu_control=0, aluin1=aluin2=16'h0000 and dr_out=0.
REQ-023 SHALL, with rst=1, override any simultaneous accept or write-back; a pending operation mid-flight is discarded.

Configuration
REQ-024 SHALL support macro LC3_DECODE_BYPASS_EN.
REQ-025 SHALL, with LC3_DECODE_BYPASS_EN defined, treat a source as not hazarded when wb_en=1 and wb_dr equals it in the same cycle, and forward wb_data as its operand value.
REQ-026 SHALL, without LC3_DECODE_BYPASS_EN, hazard such a source and stall until the cycle after the write-back.

Verification
REQ-027 SHALL check: write R1=0x0005 and R2=0x0003, then ADD R3,R1,R2 (0x1642) accepted -> next cycle alu_enable=1, alu_control=0, aluin1=0x0005, aluin2=0x0003, dr_out=3.
REQ-028 SHALL check: AND R4,R1,#-1 (0x587F) -> aluin2=0xFFFF, alu_control=1; NOT R5,R1 (0x9A7F) -> alu_control=2, aluin2=0x0000.
REQ-029 SHALL check: ADD R3 issued, then ADD R6,R3,R3 offered -> instr_ready=0 until wb_en, wb_dr=3; with bypass, accept on the wb cycle with aluin1=wb_data; without bypass, accept one cycle later.
REQ-030 SHALL check: opcode 0x0000 (BR) offered -> illegal=1 for one cycle, alu_enable=0, busy unchanged.
REQ-031 SHALL check: stall=1 for 3 cycles with a valid instruction offered -> instr_ready=0, outputs held, alu_enable=0; issue on the first cycle after stall falls.
REQ-032 SHALL check: rst asserted on the edge that would accept ADD -> next cycle alu_enable=0, all busy bits clear, R1 reads 0x0000.
